// File: rtl/serial_port_fifo.sv
// Buffered serial port: independent TX/RX FIFOs between CPU MMIO and the serial handshake pins,
// with sticky overflow flags, occupancy counts and an internal TX->RX loopback path.
module serial_port_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cpu_tx_wr,
    input  logic [DATA_WIDTH-1:0]       cpu_tx_data,
    input  logic                        cpu_rx_rd,
    output logic [DATA_WIDTH-1:0]       cpu_rx_data,
    input  logic                        cpu_clr_flags,
    input  logic                        loopback_en,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        tx_full,
    output logic                        rx_empty,
    output logic                        tx_overflow,
    output logic                        rx_overflow,
    output logic [DATA_WIDTH-1:0]       serial_out,
    output logic                        serial_wren_out,
    input  logic                        serial_ready_in,
    input  logic [DATA_WIDTH-1:0]       serial_in,
    input  logic                        serial_valid_in,
    output logic                        serial_rden_out
);

    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam logic [TxAw:0] TxFullCount = (TxAw + 1)'(TX_DEPTH);
    localparam logic [RxAw:0] RxFullCount = (RxAw + 1)'(RX_DEPTH);

    logic [DATA_WIDTH-1:0] r_tx_mem [TX_DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [RX_DEPTH];
    logic [TxAw-1:0]       r_tx_wr_ptr, r_tx_rd_ptr;
    logic [RxAw-1:0]       r_rx_wr_ptr, r_rx_rd_ptr;
    logic [TxAw:0]         r_tx_count;
    logic [RxAw:0]         r_rx_count;
    logic                  r_tx_overflow, r_rx_overflow;
    logic [DATA_WIDTH-1:0] r_serial_out;
    logic                  r_serial_wren;

    logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_ext_push;
    logic [DATA_WIDTH-1:0] w_tx_head, w_rx_wdata;

    // Full/empty are always judged on pre-edge occupancy, so a same-cycle pop never frees a slot.
    assign w_tx_full  = (r_tx_count == TxFullCount);
    assign w_tx_empty = (r_tx_count == '0);
    assign w_rx_full  = (r_rx_count == RxFullCount);
    assign w_rx_empty = (r_rx_count == '0);
    assign w_tx_head  = r_tx_mem[r_tx_rd_ptr];

    assign w_tx_push     = cpu_tx_wr & ~w_tx_full;
    assign w_tx_pop      = ~w_tx_empty & (loopback_en ? ~w_rx_full : serial_ready_in);
    assign w_rx_ext_push = ~loopback_en & serial_valid_in & ~w_rx_full;
    assign w_rx_push     = loopback_en ? w_tx_pop : w_rx_ext_push;
    assign w_rx_wdata    = loopback_en ? w_tx_head : serial_in;
    assign w_rx_pop      = cpu_rx_rd & ~w_rx_empty;

    always_ff @(posedge clock) begin
        if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= cpu_tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= w_rx_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + TxAw'(1);
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + TxAw'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + (TxAw + 1)'(1);
                2'b01:   r_tx_count <= r_tx_count - (TxAw + 1)'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + RxAw'(1);
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + RxAw'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + (RxAw + 1)'(1);
                2'b01:   r_rx_count <= r_rx_count - (RxAw + 1)'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // Overflow set takes priority over a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_overflow <= 1'b0;
            r_rx_overflow <= 1'b0;
        end else begin
            if (cpu_tx_wr & w_tx_full)                        r_tx_overflow <= 1'b1;
            else if (cpu_clr_flags)                           r_tx_overflow <= 1'b0;
            if (~loopback_en & serial_valid_in & w_rx_full)   r_rx_overflow <= 1'b1;
            else if (cpu_clr_flags)                           r_rx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_serial_out  <= '0;
            r_serial_wren <= 1'b0;
        end else if (w_tx_pop & ~loopback_en) begin
            r_serial_out  <= w_tx_head;
            r_serial_wren <= 1'b1;
        end else begin
            r_serial_wren <= 1'b0;
        end
    end

    assign serial_rden_out = w_rx_ext_push & ~reset;
    assign cpu_rx_data     = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr];
    assign tx_count        = r_tx_count;
    assign rx_count        = r_rx_count;
    assign tx_full         = w_tx_full;
    assign rx_empty        = w_rx_empty;
    assign tx_overflow     = r_tx_overflow;
    assign rx_overflow     = r_rx_overflow;
    assign serial_out      = r_serial_out;
    assign serial_wren_out = r_serial_wren;

endmodule

// File: tb/tb_serial_port_fifo.sv
// Scoreboard bench for serial_port_fifo: TX strobes and RX reads are compared against queues
// of expected bytes filled as stimulus is driven.
module tb_serial_port_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_tx_wr = 1'b0;
    logic [7:0] cpu_tx_data = '0;
    logic       cpu_rx_rd = 1'b0;
    logic [7:0] cpu_rx_data;
    logic       cpu_clr_flags = 1'b0;
    logic       loopback_en = 1'b0;
    logic [4:0] tx_count, rx_count;
    logic       tx_full, rx_empty, tx_overflow, rx_overflow;
    logic [7:0] serial_out;
    logic       serial_wren_out;
    logic       serial_ready_in = 1'b0;
    logic [7:0] serial_in = '0;
    logic       serial_valid_in = 1'b0;
    logic       serial_rden_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    serial_port_fifo #(.DATA_WIDTH(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_tx_wr       (cpu_tx_wr),
        .cpu_tx_data     (cpu_tx_data),
        .cpu_rx_rd       (cpu_rx_rd),
        .cpu_rx_data     (cpu_rx_data),
        .cpu_clr_flags   (cpu_clr_flags),
        .loopback_en     (loopback_en),
        .tx_count        (tx_count),
        .rx_count        (rx_count),
        .tx_full         (tx_full),
        .rx_empty        (rx_empty),
        .tx_overflow     (tx_overflow),
        .rx_overflow     (rx_overflow),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out),
        .serial_ready_in (serial_ready_in),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_rden_out (serial_rden_out)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Pop every expected RX byte through cpu_rx_rd, then confirm the FIFO reads back as empty.
    task automatic drain_rx();
        while (rx_q.size() != 0) begin
            check_eq("rx_data", 32'(cpu_rx_data), 32'(rx_q.pop_front()));
            cpu_rx_rd = 1'b1;
            cyc();
        end
        cpu_rx_rd = 1'b0;
        check_eq("rx_empty_after_drain", 32'(rx_empty), 32'd1);
        check_eq("rx_data_when_empty", 32'(cpu_rx_data), 32'd0);
    endtask

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (serial_wren_out) begin
            if (tx_q.size() == 0) check_eq("unexpected_strobe", 32'(serial_out), 32'hFFFF_FFFF);
            else                  check_eq("tx_data", 32'(serial_out), 32'(tx_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        check_eq("rst_tx_count", 32'(tx_count), 32'd0);
        check_eq("rst_rx_count", 32'(rx_count), 32'd0);
        check_eq("rst_tx_full", 32'(tx_full), 32'd0);
        check_eq("rst_rx_empty", 32'(rx_empty), 32'd1);
        check_eq("rst_flags", {30'd0, tx_overflow, rx_overflow}, 32'd0);
        check_eq("rst_wren", 32'(serial_wren_out), 32'd0);
        check_eq("rst_serial_out", 32'(serial_out), 32'd0);
        check_eq("rst_rx_data", 32'(cpu_rx_data), 32'd0);

        // "Hi" back-to-back, strobe one cycle after the push.
        serial_ready_in = 1'b1;
        cpu_tx_wr = 1'b1; cpu_tx_data = 8'h48; tx_q.push_back(8'h48);
        cyc();
        cpu_tx_data = 8'h69; tx_q.push_back(8'h69);
        check_eq("hi_no_strobe_yet", 32'(serial_wren_out), 32'd0);
        cyc();
        cpu_tx_wr = 1'b0;
        check_eq("hi_strobe1", 32'(serial_wren_out), 32'd1);
        check_eq("hi_byte1", 32'(serial_out), 32'h48);
        cyc();
        check_eq("hi_strobe2", 32'(serial_wren_out), 32'd1);
        check_eq("hi_byte2", 32'(serial_out), 32'h69);
        cyc();
        check_eq("hi_strobe_end", 32'(serial_wren_out), 32'd0);
        check_eq("hi_tx_count", 32'(tx_count), 32'd0);

        // Fill TX with the sink stalled; the 17th byte is dropped.
        serial_ready_in = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cpu_tx_wr = 1'b1; cpu_tx_data = 8'(i);
            if (i < 16) tx_q.push_back(8'(i));
            cyc();
        end
        cpu_tx_wr = 1'b0;
        check_eq("tx_full", 32'(tx_full), 32'd1);
        check_eq("tx_count_full", 32'(tx_count), 32'd16);
        check_eq("tx_overflow", 32'(tx_overflow), 32'd1);
        // Clear coinciding with another drop: set wins.
        cpu_tx_wr = 1'b1; cpu_tx_data = 8'h99; cpu_clr_flags = 1'b1;
        cyc();
        cpu_tx_wr = 1'b0;
        check_eq("tx_ovf_set_wins", 32'(tx_overflow), 32'd1);
        cyc();
        cpu_clr_flags = 1'b0;
        check_eq("tx_ovf_cleared", 32'(tx_overflow), 32'd0);
        serial_ready_in = 1'b1;
        for (int i = 0; i < 40 && tx_count != 0; i++) cyc();
        cyc();
        check_eq("tx_drained_count", 32'(tx_count), 32'd0);
        check_eq("tx_all_strobed", 32'(tx_q.size()), 32'd0);

        // Fill RX from the serial side until it backs up.
        serial_valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            serial_in = 8'hA0 + 8'(i);
            #1;
            check_eq("rx_rden_accept", 32'(serial_rden_out), 32'd1);
            rx_q.push_back(serial_in);
            cyc();
        end
        serial_in = 8'hB0;
        #1;
        check_eq("rx_rden_full", 32'(serial_rden_out), 32'd0);
        cyc();
        check_eq("rx_overflow", 32'(rx_overflow), 32'd1);
        check_eq("rx_count_full", 32'(rx_count), 32'd16);
        check_eq("rx_pop_head", 32'(cpu_rx_data), 32'(rx_q.pop_front()));
        cpu_rx_rd = 1'b1;
        cyc();
        cpu_rx_rd = 1'b0;
        #1;
        check_eq("rx_rden_after_pop", 32'(serial_rden_out), 32'd1);
        rx_q.push_back(8'hB0);
        cyc();
        serial_valid_in = 1'b0;
        drain_rx();
        cpu_clr_flags = 1'b1;
        cyc();
        cpu_clr_flags = 1'b0;
        check_eq("rx_ovf_cleared", 32'(rx_overflow), 32'd0);

        // Simultaneous capture and read at rx_count=5.
        serial_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            serial_in = 8'hC0 + 8'(i);
            rx_q.push_back(serial_in);
            cyc();
        end
        check_eq("rx_count_5", 32'(rx_count), 32'd5);
        serial_in = 8'hC5; rx_q.push_back(8'hC5);
        check_eq("rx_simul_head", 32'(cpu_rx_data), 32'(rx_q.pop_front()));
        cpu_rx_rd = 1'b1;
        cyc();
        cpu_rx_rd = 1'b0; serial_valid_in = 1'b0;
        check_eq("rx_count_simul", 32'(rx_count), 32'd5);
        drain_rx();

        // Loopback: external input ignored, no strobes, bytes land in RX.
        loopback_en = 1'b1; serial_ready_in = 1'b0;
        serial_valid_in = 1'b1; serial_in = 8'hEE;
        cpu_tx_wr = 1'b1; cpu_tx_data = 8'h55; rx_q.push_back(8'h55);
        #1;
        check_eq("lb_rden", 32'(serial_rden_out), 32'd0);
        cyc();
        cpu_tx_data = 8'hAA; rx_q.push_back(8'hAA);
        cyc();
        cpu_tx_wr = 1'b0;
        for (int i = 0; i < 10 && rx_count != 2; i++) cyc();
        check_eq("lb_rx_count", 32'(rx_count), 32'd2);
        check_eq("lb_tx_count", 32'(tx_count), 32'd0);
        check_eq("lb_rx_overflow", 32'(rx_overflow), 32'd0);
        drain_rx();
        loopback_en = 1'b0; serial_valid_in = 1'b0;

        // Reset in the middle of a drain.
        for (int i = 0; i < 2; i++) begin
            serial_valid_in = 1'b1; serial_in = 8'hD0 + 8'(i);
            cyc();
        end
        serial_valid_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cpu_tx_wr = 1'b1; cpu_tx_data = 8'hE0 + 8'(i); tx_q.push_back(cpu_tx_data);
            cyc();
        end
        cpu_tx_wr = 1'b0;
        check_eq("pre_rst_tx_count", 32'(tx_count), 32'd10);
        serial_ready_in = 1'b1;
        cyc();
        cyc();
        check_eq("mid_drain_tx_count", 32'(tx_count), 32'd8);
        reset = 1'b1;
        cyc();
        tx_q.delete();
        check_eq("mrst_tx_count", 32'(tx_count), 32'd0);
        check_eq("mrst_rx_count", 32'(rx_count), 32'd0);
        check_eq("mrst_wren", 32'(serial_wren_out), 32'd0);
        check_eq("mrst_flags", {30'd0, tx_overflow, rx_overflow}, 32'd0);
        check_eq("mrst_rx_data", 32'(cpu_rx_data), 32'd0);
        reset = 1'b0;
        cyc();
        cyc();
        check_eq("post_rst_wren", 32'(serial_wren_out), 32'd0);
        check_eq("post_rst_tx_count", 32'(tx_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
